uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Frame controller for the UART receiver. Detects the start bit and runs the per-bit
//  edge/bit counters. Drives dat_samp_en and edge_cnt into the 3-sample majority sampler,
//  and consumes its sampled_bit. Deserialises LSB-first data, checks parity and stop bit,
//  and emits a one-cycle data_valid with the parallel word.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  PRESC_W     6  width of Prescale / edge_cnt
// PORTS
//  CLK          in   1           receiver oversampling clock
//  RST          in   1           asynchronous, active-low reset
//  RX_IN        in   1           serial line (idle high)
//  Prescale     in   PRESC_W     oversampling ratio; legal values 8, 16, 32
//  PAR_EN       in   1           1 = frame carries a parity bit
//  PAR_TYP      in   1           0 = even, 1 = odd
//  sampled_bit  in   1           majority bit from sampler
//  dat_samp_en  out  1           sampler enable
//  edge_cnt     out  PRESC_W     oversampling edge index within the current bit, 0..Prescale-1
//  bit_cnt      out  4           bit index in frame: 0 = start, 1..8 = data, 9 = parity/stop, 10 = stop
//  P_DATA       out  DATA_WIDTH  received word, LSB first on the line
//  data_valid   out  1           1-cycle pulse, frame error-free
//  par_err      out  1           parity mismatch, held until next start
//  stp_err      out  1           stop bit sampled 0, held until next start
//  strt_glitch  out  1           1-cycle pulse, start bit rejected
//  busy         out  1           high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, latched prescale = 8. Reset mid-frame aborts the frame; no data_valid.
//  - Prescale and PAR_EN/PAR_TYP are latched on start detection (cycle RX_IN==0 seen in IDLE).
//    Later changes take effect at the next frame.
//  - Counters: edge_cnt increments each cycle when counting. At latched P-1 it wraps to 0 and
//    bit_cnt increments. Counting is enabled in START/DATA/PARITY/STOP, and in IDLE on the
//    detection cycle (that cycle is edge 0). Counters clear in IDLE and OUT.
//  - Sampler timing: sampled_bit for the current bit is valid from edge_cnt == P/2+3 to P-1.
//  - START, DATA and PARITY consume sampled_bit at edge_cnt == P-1. STOP consumes it at
//    P/2+3, leaving half a bit of margin for a back-to-back start.
//  - dat_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and OUT.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
//    IDLE:   RX_IN==0 -> START; clear par_err and stp_err.
//    START:  at P-1: bit 0 -> DATA; bit 1 -> IDLE and pulse strt_glitch.
//    DATA:   at P-1, P_DATA <= {sampled_bit, P_DATA[W-1:1]}.
//            After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
//    PARITY: at P-1, expected = ^P_DATA ^ PAR_TYP. Mismatch sets par_err. Always -> STOP.
//    STOP:   at P/2+3, stp_err <= ~sampled_bit; -> OUT.
//    OUT:    1 cycle. data_valid = ~par_err & ~stp_err. Then -> IDLE.
//            RX_IN==0 in IDLE is a new start.
//  - P_DATA holds its value until the next DATA shift; it is not cleared between frames.
//  - Errored frames never assert data_valid. The error flags remain readable until the next start.
//  - Simultaneous events: a wrap with a state change uses the new state's counter rule
//    (cleared in OUT/IDLE).
// STRUCTURE
//  - uart_rx_pkg: state encoding localparams, PAR_EVEN/PAR_ODD constants, bit index
//    constants (BIT_START = 0, BIT_PAR = 9).
//  - Sub-module uart_rx_edge_bit_cnt: edge_cnt/bit_cnt with enable, clear and latched
//    prescale wrap. The FSM, deserialiser and checks stay in uart_rx_ctrl.
// TESTING (bench instantiates the real sampler)
//  1. P=8, no parity, byte 0xA5, stop 1 -> data_valid pulses once, P_DATA=0xA5,
//     par_err=0, stp_err=0.
//  2. P=16, PAR_EN=1, even, byte 0x37 (five 1s), parity bit 1 -> data_valid, P_DATA=0x37.
//     Repeat with parity bit 0 -> par_err=1, no data_valid.
//  3. P=8, 0x55 with stop bit 0 -> stp_err=1, no data_valid; next frame 0x0F -> flags
//     clear at start, data_valid, P_DATA=0x0F.
//  4. 2-cycle low glitch on idle line, P=16 -> strt_glitch pulse, state IDLE, no data_valid.
//  5. Back-to-back frames 0x12, 0x34 (no idle gap), P=32 -> two data_valid pulses with
//     correct words.
//  6. RST low at bit_cnt=4 mid-frame -> all outputs 0 immediately; next clean frame
//     0xC3 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding, parity kinds and frame bit indices.
package uart_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_OUT    = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_PAR   = 4'd9;

    localparam int unsigned PRESC_RST = 8;

    // States in which the edge/bit counters advance.
    function automatic logic counting(input state_t s);
        return (s == ST_START) || (s == ST_DATA) ||
               (s == ST_PARITY) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter.
// Prescale is captured on load and used for the wrap point.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic [PRESC_W-1:0] presc_in,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    output logic [PRESC_W-1:0] presc_q,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               edge_last
);

    assign edge_last = (edge_cnt == presc_q - PRESC_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q <= PRESC_W'(PRESC_RST);
        end else if (load) begin
            presc_q <= presc_in;
        end
    end

    // Clear wins over enable so a wrap into IDLE/OUT lands on zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (edge_last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, deserialise,
// parity and stop checks, one-cycle data_valid per clean frame.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESC_W-1:0]    edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    state_t             st_q;
    state_t             st_d;
    logic               detect;
    logic               edge_last;
    logic               edge_mid;
    logic               cnt_en;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_exp;
    logic [PRESC_W-1:0] presc_q;

    assign detect   = (st_q == ST_IDLE) && !RX_IN;
    assign edge_mid = (edge_cnt == (presc_q >> 1) + PRESC_W'(3));
    assign par_exp  = (^P_DATA) ^ par_typ_q;

    // Counters follow the state being entered, not the one left.
    assign cnt_en = counting(st_d);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .load      (detect),
        .presc_in  (Prescale),
        .cnt_en    (cnt_en),
        .cnt_clr   (!cnt_en),
        .presc_q   (presc_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .edge_last (edge_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE: begin
                if (!RX_IN) st_d = ST_START;
            end
            ST_START: begin
                if (edge_last) st_d = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (edge_last && bit_cnt == 4'(DATA_WIDTH))
                    st_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (edge_last) st_d = ST_STOP;
            end
            ST_STOP: begin
                if (edge_mid) st_d = ST_OUT;
            end
            ST_OUT: begin
                st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dat_samp_en = 1'b0;
        busy        = 1'b0;
        data_valid  = 1'b0;
        unique case (1'b1)
            (st_q == ST_IDLE): begin
                busy = 1'b0;
            end
            (st_q == ST_OUT): begin
                busy       = 1'b1;
                data_valid = !par_err && !stp_err;
            end
            default: begin
                busy        = 1'b1;
                dat_samp_en = counting(st_q);
            end
        endcase
    end

    // Frame options are frozen at detection for the whole frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (detect) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA <= '0;
        end else if (st_q == ST_DATA && edge_last) begin
            P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else if (detect) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else begin
            if (st_q == ST_PARITY && edge_last)
                par_err <= (sampled_bit != par_exp);
            if (st_q == ST_STOP && edge_mid)
                stp_err <= !sampled_bit;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            strt_glitch <= 1'b0;
        end else begin
            strt_glitch <= (st_q == ST_START) && edge_last && sampled_bit;
        end
    end

endmodule
